reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/reg_bank_rd_port.sv | 62 ++++++
 rtl/reg_bank.sv | 122 ++++++++++++
 tb/tb_reg_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared FSM state type and byte-merge helper for reg_bank
package reg_bank_pkg;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   // One byte lane of a masked write: the new byte where enabled, the old byte otherwise.
   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// rtl/reg_bank_rd_port.sv - one registered read port; REG_BANK_BYPASS_EN adds write-to-read forwarding
module reg_bank_rd_port #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_en,
   input  logic [AW-1:0]               i_addr,
   input  logic [DEPTH-1:0][WIDTH-1:0] i_mem,
   input  logic                        i_w_acc,
   input  logic [AW-1:0]               i_w_addr,
   input  logic [WIDTH-1:0]            i_w_value,
   input  logic [WIDTH/8-1:0]          i_w_be,
   output logic [WIDTH-1:0]            o_value,
   output logic                        o_valid
);
   import reg_bank_pkg::*;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic             w_in_range;
   logic [WIDTH-1:0] w_stored;
   logic [WIDTH-1:0] w_data;

   // Addresses past the last register read as zero rather than aliasing.
   assign w_in_range = ({1'b0, i_addr} < LP_DEPTH);
   assign w_stored   = w_in_range ? i_mem[i_addr] : '0;

`ifdef REG_BANK_BYPASS_EN
   logic             w_hit;
   logic [WIDTH-1:0] w_merged;

   // An accepted write to the same address this cycle is forwarded with its byte mask applied.
   assign w_hit = i_w_acc && (i_w_addr == i_addr);
   for (genvar b = 0; b < WIDTH/8; b++) begin : g_merge
      assign w_merged[8*b +: 8] = merge_byte(w_stored[8*b +: 8], i_w_value[8*b +: 8], i_w_be[b]);
   end
   assign w_data = w_hit ? w_merged : w_stored;
`else
   logic w_unused;

   // Without forwarding a colliding read returns the pre-write contents.
   assign w_unused = ^{i_w_acc, i_w_addr, i_w_value, i_w_be};
   assign w_data   = w_stored;
`endif

   // Output register: valid for one cycle per request, data held between requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_value <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= i_en;
         if (i_en) begin
            o_value <= w_data;
         end
      end
   end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - multi-port register bank with ID register, byte writes and bulk clear (option: REG_BANK_BYPASS_EN)
module reg_bank #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 32,
   parameter int               NRD      = 2,
   parameter logic [WIDTH-1:0] ID_VALUE = 'hb00,
   localparam int              AW       = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_w_en,
   input  logic [AW-1:0]                 i_w_addr,
   input  logic [WIDTH-1:0]              i_w_value,
   input  logic [WIDTH/8-1:0]            i_w_be,
   input  logic [NRD-1:0]                i_r_en,
   input  logic [NRD-1:0][AW-1:0]        i_r_addr,
   output logic [NRD-1:0][WIDTH-1:0]     o_r_value,
   output logic [NRD-1:0]                o_r_valid,
   input  logic                          i_clr,
   output logic                          o_busy,
   output logic                          o_w_err
);
   import reg_bank_pkg::*;

   localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH-1);

   state_t                      r_state;
   state_t                      w_next_state;
   logic [AW-1:0]               r_clr_addr;
   logic [WIDTH-1:0]            r_mem [DEPTH];
   logic [DEPTH-1:0][WIDTH-1:0] w_mem;
   logic [WIDTH-1:0]            w_merged;
   logic                        w_acc;
   logic                        w_rej;
   logic                        r_w_err;

   // Writes are refused while clearing, on the cycle that starts a clear, to the ID register and past the end.
   assign w_acc = i_w_en && (r_state == IDLE) && !i_clr
                  && (i_w_addr != '0) && ({1'b0, i_w_addr} < LP_DEPTH);
   assign w_rej = i_w_en && !w_acc;

   for (genvar b = 0; b < WIDTH/8; b++) begin : g_wmerge
      assign w_merged[8*b +: 8] = merge_byte(r_mem[i_w_addr][8*b +: 8], i_w_value[8*b +: 8], i_w_be[b]);
   end

   // Read-side view: register 0 is the constant ID, the rest come from storage.
   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      if (i == 0) begin : g_id
         assign w_mem[i] = ID_VALUE;
      end else begin : g_reg
         assign w_mem[i] = r_mem[i];
      end
   end

   // State register and clear address; the address is preloaded to 1 while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_clr_addr <= AW'(1);
      end else begin
         r_state    <= w_next_state;
         r_clr_addr <= (r_state == IDLE) ? AW'(1) : r_clr_addr + AW'(1);
      end
   end

   // Next-state: start on i_clr, stay until the last register has been zeroed.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_clr) w_next_state = CLEAR;
         CLEAR:   if (r_clr_addr == LP_LAST) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Storage: masked writes in IDLE, one register zeroed per cycle in CLEAR.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_acc) begin
         r_mem[i_w_addr] <= w_merged;
      end else if (r_state == CLEAR) begin
         r_mem[r_clr_addr] <= '0;
      end
   end

   // Rejected-write flag, a one-cycle pulse after the offending request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w_err <= 1'b0;
      end else begin
         r_w_err <= w_rej;
      end
   end

   assign o_w_err = r_w_err;
   assign o_busy  = (r_state == CLEAR);

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      reg_bank_rd_port #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_rd_port (
         .clk       (clk),
         .reset     (reset),
         .i_en      (i_r_en[p]),
         .i_addr    (i_r_addr[p]),
         .i_mem     (w_mem),
         .i_w_acc   (w_acc),
         .i_w_addr  (i_w_addr),
         .i_w_value (i_w_value),
         .i_w_be    (i_w_be),
         .o_value   (o_r_value[p]),
         .o_valid   (o_r_valid[p])
      );
   end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed self-checking bench for reg_bank (expects REG_BANK_BYPASS_EN to match the DUT build)
module tb_reg_bank;
   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      i_w_en;
   logic [AW-1:0]             i_w_addr;
   logic [WIDTH-1:0]          i_w_value;
   logic [WIDTH/8-1:0]        i_w_be;
   logic [NRD-1:0]            i_r_en;
   logic [NRD-1:0][AW-1:0]    i_r_addr;
   logic [NRD-1:0][WIDTH-1:0] o_r_value;
   logic [NRD-1:0]            o_r_valid;
   logic                      i_clr;
   logic                      o_busy;
   logic                      o_w_err;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cycles;
   logic [15:0] exp_collide;

   always #5 clk = ~clk;

   reg_bank #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .ID_VALUE (16'hb00)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_w_en    (i_w_en),
      .i_w_addr  (i_w_addr),
      .i_w_value (i_w_value),
      .i_w_be    (i_w_be),
      .i_r_en    (i_r_en),
      .i_r_addr  (i_r_addr),
      .o_r_value (o_r_value),
      .o_r_valid (o_r_valid),
      .i_clr     (i_clr),
      .o_busy    (o_busy),
      .o_w_err   (o_w_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] fill_val(input int a);
      return 16'(32'h1000 + a * 32'h0101);
   endfunction

   task automatic do_write(input logic [AW-1:0] a, input logic [15:0] v, input logic [1:0] be);
      i_w_en    = 1'b1;
      i_w_addr  = a;
      i_w_value = v;
      i_w_be    = be;
      tick();
      i_w_en    = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      i_r_en      = 2'b11;
      i_r_addr[0] = a0;
      i_r_addr[1] = a1;
      tick();
      i_r_en      = 2'b00;
   endtask

   initial begin
      reset = 1'b1; i_w_en = 1'b0; i_w_addr = '0; i_w_value = '0; i_w_be = '0;
      i_r_en = '0; i_r_addr = '0; i_clr = 1'b0;
      tick();
      tick();
      // inputs active while reset is held must have no effect
      i_w_en = 1'b1; i_w_addr = 5'd3; i_w_value = 16'hFFFF; i_w_be = 2'b11;
      i_r_en = 2'b11; i_clr = 1'b1;
      tick();
      i_w_en = 1'b0; i_r_en = 2'b00; i_clr = 1'b0;
      reset = 1'b0;
      check("rst_busy", o_busy, 0);
      check("rst_werr", o_w_err, 0);
      check("rst_valid", o_r_valid, 0);
      check("rst_val0", o_r_value[0], 0);
      check("rst_val1", o_r_value[1], 0);

      do_read(5'd0, 5'd5);
      check("rd_valid", o_r_valid, 2'b11);
      check("rd_id", o_r_value[0], 16'hb00);
      check("rd_a5", o_r_value[1], 16'h0000);
      tick();
      check("rd_valid_drop", o_r_valid, 2'b00);
      check("rd_hold", o_r_value[0], 16'hb00);
      check("tick_busy_idle", o_busy, 0);

      do_read(5'd3, 5'd3);
      check("rst_write_ignored", o_r_value[0], 16'h0000);

      do_write(5'd3, 16'hABCD, 2'b11);
      check("wr_ok_noerr", o_w_err, 0);
      do_write(5'd3, 16'h1234, 2'b01);
      do_read(5'd3, 5'd0);
      check("be_lo", o_r_value[0], 16'hAB34);
      check("be_id", o_r_value[1], 16'hb00);

      do_write(5'd3, 16'h77FF, 2'b10);
      do_read(5'd3, 5'd3);
      check("be_hi_p0", o_r_value[0], 16'h7734);
      check("be_hi_p1", o_r_value[1], 16'h7734);

      do_write(5'd0, 16'hDEAD, 2'b11);
      check("wr0_err", o_w_err, 1);
      tick();
      check("wr0_err_pulse", o_w_err, 0);
      do_read(5'd0, 5'd0);
      check("wr0_id_p0", o_r_value[0], 16'hb00);
      check("wr0_id_p1", o_r_value[1], 16'hb00);

`ifdef REG_BANK_BYPASS_EN
      exp_collide = 16'h5555;
`else
      exp_collide = 16'h1111;
`endif
      do_write(5'd7, 16'h1111, 2'b11);
      i_w_en = 1'b1; i_w_addr = 5'd7; i_w_value = 16'h5555; i_w_be = 2'b11;
      i_r_en = 2'b10; i_r_addr[1] = 5'd7;
      tick();
      i_w_en = 1'b0; i_r_en = 2'b00;
      check("collide", o_r_value[1], exp_collide);
      do_read(5'd7, 5'd7);
      check("collide_after", o_r_value[0], 16'h5555);

      for (int a = 1; a < DEPTH; a++) do_write(AW'(a), fill_val(a), 2'b11);
      do_read(5'd31, 5'd1);
      check("fill31", o_r_value[0], fill_val(31));
      check("fill1", o_r_value[1], fill_val(1));

      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      check("clr_busy", o_busy, 1);
      busy_cycles = 0;
      while (o_busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         if (busy_cycles == 2) begin
            i_r_en = 2'b01; i_r_addr[0] = 5'd31; i_clr = 1'b1;
         end
         if (busy_cycles == 5) begin
            i_w_en = 1'b1; i_w_addr = 5'd4; i_w_value = 16'hFFFF; i_w_be = 2'b11;
            i_r_en = 2'b11; i_r_addr[0] = 5'd30; i_r_addr[1] = 5'd1;
         end
         tick();
         i_r_en = 2'b00; i_clr = 1'b0; i_w_en = 1'b0;
         if (busy_cycles == 2) check("clr_rd_pending", o_r_value[0], fill_val(31));
         if (busy_cycles == 5) begin
            check("clr_wr_err", o_w_err, 1);
            check("clr_rd_pending30", o_r_value[0], fill_val(30));
            check("clr_rd_done1", o_r_value[1], 16'h0000);
         end
      end
      check("clr_len", busy_cycles, 31);
      for (int a = 0; a < DEPTH; a += 2) begin
         do_read(AW'(a), AW'(a + 1));
         check($sformatf("clr_rd%0d", a), o_r_value[0], (a == 0) ? 16'hb00 : 16'h0000);
         check($sformatf("clr_rd%0d", a + 1), o_r_value[1], 16'h0000);
      end

      do_write(5'd20, 16'h2020, 2'b11);
      do_write(5'd31, 16'h3131, 2'b11);
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      check("abort_busy_pre", o_busy, 1);
      reset = 1'b1;
      i_w_en = 1'b1; i_w_addr = 5'd5; i_w_value = 16'h5A5A; i_w_be = 2'b11;
      tick();
      reset = 1'b0; i_w_en = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_werr", o_w_err, 0);
      do_read(5'd20, 5'd31);
      check("abort_a20", o_r_value[0], 16'h0000);
      check("abort_a31", o_r_value[1], 16'h0000);
      do_read(5'd0, 5'd5);
      check("abort_id", o_r_value[0], 16'hb00);
      check("abort_a5", o_r_value[1], 16'h0000);

      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      check("reclr_busy", o_busy, 1);
      busy_cycles = 0;
      while (o_busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         tick();
      end
      check("reclr_len", busy_cycles, 31);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
